// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: transforms a 128-bit state LANES bytes per clock
// through LANES copies of the FIPS-197 inverse S-box, with valid/ready handshakes.
module inv_sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned Groups = 16 / LANES;
  localparam int unsigned CntW   = (Groups > 1) ? $clog2(Groups) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Groups - 1);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] InvSboxTbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return InvSboxTbl[idx +: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [127:0]      r_work, w_work_d;
  logic [7:0]        w_sub_in  [LANES];
  logic [7:0]        w_sub_out [LANES];

  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      w_sub_in[l] = '0;
      for (int g = 0; g < int'(Groups); g++) begin
        if (r_cnt == CntW'(g)) w_sub_in[l] = r_work[8*(g*LANES+l) +: 8];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_sub_out[l] = inv_sbox(w_sub_in[l]);
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_work_d  = r_work;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_work_d  = in_state;
          w_cnt_d   = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        for (int g = 0; g < int'(Groups); g++) begin
          if (r_cnt == CntW'(g)) begin
            for (int l = 0; l < int'(LANES); l++) w_work_d[8*(g*LANES+l) +: 8] = w_sub_out[l];
          end
        end
        if (r_cnt == CntLast) begin
          w_cnt_d   = '0;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_work  <= w_work_d;
    end
  end

  // All handshake outputs are pure functions of the state register.
  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign out_state = r_work;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq: directed vectors, stall, reset and a
// random stream checked against an S-box model derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_seq;

  localparam logic [127:0] V25 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] E25 = 128'hfbd7f3819ea340bf38a53630d56a0952;

  logic         clk = 0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;

  logic         s_in_valid;
  logic [127:0] s_in_state;
  logic [3:0]   s_in_ready, s_out_valid, s_busy;
  logic [127:0] s_out_state [4];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rdy_mode = 0;

  logic [127:0] exp_q [$];
  int           lat_q [$];
  logic [7:0]   inv_tbl [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes_seq #(.LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  for (genvar j = 0; j < 4; j++) begin : g_sec
    inv_sub_bytes_seq #(.LANES((j < 2) ? j + 1 : ((j == 2) ? 8 : 16))) u_sec (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[j]),
      .in_state(s_in_state), .out_valid(s_out_valid[j]), .out_ready(1'b1),
      .out_state(s_out_state[j]), .busy(s_busy[j])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = (x == 8'h00) ? 8'h00 : 8'h01;
    if (x != 8'h00) for (int i = 0; i < 254; i++) b = gmul(b, x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tbl[s[8*i +: 8]];
    return r;
  endfunction

  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk_int("send_timeout", 0, 1);
      return;
    end
    in_valid = 1;
    in_state = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    lat_q.push_back(cyc);
    in_valid = 0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk_int("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: latency on each rising out_valid, result on each handshake.
  initial begin
    logic prev_v;
    int   a;
    prev_v = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 0;
      end else begin
        if (out_valid && !prev_v) begin
          if (lat_q.size() == 0) chk_int("spurious_out_valid", 1, 0);
          else begin
            a = lat_q.pop_front();
            chk_int("latency", cyc - a, 4);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk_int("extra_result", 1, 0);
          else chk("result", out_state, exp_q.pop_front());
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 0;
      endcase
    end
  end

  initial begin
    int          acc, n, flag;
    logic [3:0]  seen;
    int          got_lat [4];
    int          exp_lat [4];
    logic [127:0] d;
    exp_lat = '{16, 8, 2, 1};

    rst_n = 0; in_valid = 0; in_state = '0; out_ready = 0;
    s_in_valid = 0; s_in_state = '0;
    for (int i = 0; i < 256; i++) inv_tbl[fwd_sbox(8'(i))] = 8'(i);
    #12;
    chk("rst_out_state", out_state, 128'h0);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_in_ready", int'(in_ready), 1);
    chk_int("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1;

    // Other lane counts on the same vector.
    @(negedge clk);
    s_in_valid = 1;
    s_in_state = V25;
    @(posedge clk);
    #1;
    acc = cyc;
    s_in_valid = 0;
    seen = '0;
    for (int j = 0; j < 4; j++) got_lat[j] = 999;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (s_out_valid[j] && !seen[j]) begin
          seen[j] = 1;
          got_lat[j] = cyc - acc;
          chk($sformatf("lanes_result_%0d", j), s_out_state[j], E25);
        end
      end
    end
    for (int j = 0; j < 4; j++) chk_int($sformatf("lanes_latency_%0d", j), got_lat[j], exp_lat[j]);

    // Directed vectors with hand-computed results.
    rdy_mode = 0;
    send(V25, E25);
    send({16{8'h63}}, 128'h0);
    send({16{8'hff}}, {16{8'h7d}});
    send({16{8'h7c}}, {16{8'h01}});
    drain(200);

    // Output stall with in_valid noise.
    @(negedge clk);
    rdy_mode = 2;
    out_ready = 0;
    send(V25, E25);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 6; k++) begin
      chk("stall_out_state", out_state, E25);
      chk_int("stall_out_valid", int'(out_valid), 1);
      chk_int("stall_in_ready", int'(in_ready), 0);
      in_valid = ~in_valid;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 0;
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk_int("stall_back_idle", int'(in_ready), 1);
    chk_int("stall_valid_low", int'(out_valid), 0);
    drain(50);

    // Reset during RUN cycle 2 abandons the operation.
    @(negedge clk);
    in_valid = 1;
    in_state = V25;
    @(posedge clk);
    #1;
    in_valid = 0;
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("midrun_rst_out_state", out_state, 128'h0);
    chk_int("midrun_rst_out_valid", int'(out_valid), 0);
    chk_int("midrun_rst_in_ready", int'(in_ready), 1);
    chk_int("midrun_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    flag = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) flag = 1;
    end
    chk_int("no_valid_after_reset", flag, 0);

    // First edge after reset release accepts a state.
    @(negedge clk);
    rst_n = 0;
    in_valid = 1;
    in_state = {16{8'h7c}};
    exp_q.push_back({16{8'h01}});
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    lat_q.push_back(cyc);
    in_valid = 0;
    chk_int("accept_after_release", int'(busy), 1);
    drain(50);

    // Random stream with random back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 100; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, model(d));
    end
    drain(3000);
    chk_int("latency_queue_empty", lat_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

Interface
REQ-001 SHALL provide parameter LANES, default 4, number of state bytes substituted per clock; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port in_valid  input  1  in_state carries a 128-bit AES state to transform.
REQ-005 SHALL provide port in_ready  output  1  block can accept a state this cycle.
REQ-006 SHALL provide port in_state  input  128  ciphertext-side state; byte i = bits [8i+7:8i], i = 0..15.
REQ-007 SHALL provide port out_valid  output  1  out_state holds a completed InvSubBytes result.
REQ-008 SHALL provide port out_ready  input  1  consumer accepts out_state this cycle.
REQ-009 SHALL provide port out_state  output  128  result; byte i = InvSbox(input byte i).
REQ-010 SHALL provide port busy  output  1  high in RUN and DONE states.

Function
REQ-011 SHALL substitute bytes through LANES instances of the existing combinational 8-bit inverse S-box (FIPS-197 InvSbox); no other lookup table is permitted.
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; when in_valid=1, SHALL latch in_state into the 128-bit working register, clear group counter, and go to RUN.
REQ-014 RUN: each cycle SHALL replace bytes [cnt*LANES .. cnt*LANES+LANES-1] of the working register in place with their InvSbox values and increment cnt.
REQ-015 Counter width SHALL be ceil(log2(16/LANES)), minimum 1 bit; when cnt = 16/LANES-1, the group is written, cnt wraps to 0, and the FSM goes to DONE.
REQ-016 Latency SHALL be exactly 16/LANES cycles from the accepting edge to the first cycle out_valid=1, i.e. 4 cycles at LANES=4 and 16 at LANES=1.
REQ-017 DONE: out_valid=1; out_state SHALL hold stable until the out_valid&&out_ready edge, after which the FSM goes to IDLE.
REQ-018 in_ready SHALL be 1 only in IDLE; in_valid in RUN/DONE SHALL be ignored and must not corrupt the working register.
REQ-019 out_state SHALL be driven directly from the working register in all states; its value is meaningful only when out_valid=1.
REQ-020 No combinational path SHALL exist from out_ready or in_valid to in_ready or out_valid.
REQ-021 Back-to-back operation: a new state is accepted at the earliest one cycle after the output handshake; throughput is 1 state per 16/LANES+2 cycles.

Reset
REQ-022 While rst_n=0, SHALL force FSM=IDLE, cnt=0, working register=0; thus in_ready=1, out_valid=0, busy=0, out_state=0.
REQ-023 Reset asserted mid-RUN or mid-DONE SHALL abandon the operation immediately and produce no out_valid after release.
REQ-024 The first active edge after rst_n deassertion SHALL be able to accept in_valid.

Verification
REQ-025 in_state=128'h0f0e0d0c0b0a09080706050403020100, LANES=4 -> out_valid rises 4 cycles after acceptance, out_state=128'hfbd7f3819ea340bf38a53630d56a0952.
REQ-026 in_state all bytes 8'h63 -> out_state=128'h0; in_state all 8'hff -> all bytes 8'h7d; in_state all 8'h7c -> all bytes 8'h01.
REQ-027 out_ready held low 6 cycles in DONE while in_valid toggles with random data -> out_state, out_valid stable; in_ready=0 throughout; handshake returns to IDLE next cycle.
REQ-028 rst_n pulsed low during RUN cycle 2 -> outputs at reset values asynchronously; no out_valid afterwards until a new state is accepted.
REQ-029 Run the REQ-025 vector with LANES=1, 2, 8 and 16 -> identical out_state; latency 16, 8, 2 and 1 cycles respectively.
REQ-030 Stream 100 random states with random out_ready against a software InvSbox model -> every result matches, and no state is dropped or duplicated.
